coord_bank_writer: RTL and testbench

- Parametrised multi-bank coordinate store writer. Streams (x,y) samples into a banked memory; each bank is a session opened by i_start and closed by i_deny or by the bank filling up.
- Address is {bank, entry}. The block records each closed bank's entry count in a length table with a combinational read port.
- Sits between the coordinate producer and the SRAM write port. Optional bank wrap-around, or a sticky full stop.

---
 rtl/coord_store_pkg.sv | 17 +
 rtl/bank_len_table.sv | 43 ++++
 rtl/coord_bank_writer.sv | 125 ++++++++++++
 tb/tb_coord_bank_writer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/coord_store_pkg.sv
// Shared types and helpers for the coordinate bank writer.
// Holds the FSM state encoding and the bank-index width helper.
package coord_store_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WORK  = 2'd1,
        CLOSE = 2'd2,
        FULL  = 2'd3
    } state_t;

    // A single-bit index is kept even for degenerate bank counts.
    function automatic int calc_bank_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bank_len_table.sv
// Per-bank length table: one synchronous write port with clear,
// one combinational read port; out-of-range reads return 0.
module bank_len_table
    import coord_store_pkg::*;
#(
    parameter int BANK_NUM = 26,
    parameter int LEN_W    = 11,
    localparam int IDX_W   = calc_bank_w(BANK_NUM)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic             i_wr_clr,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [LEN_W-1:0] i_wr_len,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [LEN_W-1:0] o_rd_len
);

    logic [LEN_W-1:0] r_len [BANK_NUM];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < BANK_NUM; i++) begin
                r_len[i] <= '0;
            end
        end else if (int'(i_wr_idx) < BANK_NUM) begin
            if (i_wr_clr) begin
                r_len[i_wr_idx] <= '0;
            end else if (i_wr_en) begin
                r_len[i_wr_idx] <= i_wr_len;
            end
        end
    end

    always_comb begin
        o_rd_len = '0;
        if (int'(i_rd_idx) < BANK_NUM) begin
            o_rd_len = r_len[i_rd_idx];
        end
    end

endmodule

// File: rtl/coord_bank_writer.sv
// Streams (x,y) samples into a banked store addressed {bank, entry}
// and records each closed bank's entry count in a length table.
//
// state | meaning
// IDLE  | waiting for i_start to open bank r_bank
// WORK  | writing samples; closes on i_deny or when the bank fills
// CLOSE | one cycle: record length, advance or wrap the bank
// FULL  | last bank closed without wrap; sticky until reset
module coord_bank_writer
    import coord_store_pkg::*;
#(
    parameter int COORD_W  = 5,
    parameter int BANK_NUM = 26,
    parameter int DEPTH_W  = 10,
    parameter int WRAP_EN  = 1,
    localparam int BANK_W  = calc_bank_w(BANK_NUM)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic                      i_valid,
    input  logic [COORD_W-1:0]        i_x,
    input  logic [COORD_W-1:0]        i_y,
    input  logic                      i_deny,
    output logic                      o_we,
    output logic [COORD_W-1:0]        o_x,
    output logic [COORD_W-1:0]        o_y,
    output logic [BANK_W+DEPTH_W-1:0] o_addr,
    output logic [BANK_W-1:0]         o_bank,
    output logic                      o_busy,
    output logic                      o_full,
    input  logic [BANK_W-1:0]         i_len_bank,
    output logic [DEPTH_W:0]          o_len
);

    localparam logic [DEPTH_W:0]  CNT_LAST  = (DEPTH_W+1)'((1 << DEPTH_W) - 1);
    localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(BANK_NUM - 1);

    state_t              r_state;
    logic [BANK_W-1:0]   r_bank;
    logic [DEPTH_W:0]    r_cnt;
    logic                r_busy;
    logic                r_full;

    logic                w_write;
    logic                w_len_we;
    logic                w_len_clr;

    // Deny takes priority over a same-cycle valid sample.
    assign w_write   = (r_state == WORK) && i_valid && !i_deny;
    assign w_len_clr = (r_state == IDLE) && i_start;
    assign w_len_we  = (r_state == CLOSE);

    assign o_we   = w_write;
    assign o_x    = w_write ? i_x : '0;
    assign o_y    = w_write ? i_y : '0;
    assign o_addr = {r_bank, r_cnt[DEPTH_W-1:0]};
    assign o_bank = r_bank;
    assign o_busy = r_busy;
    assign o_full = r_full;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_bank  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_full  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= WORK;
                    end
                end
                WORK: begin
                    if (i_deny) begin
                        r_state <= CLOSE;
                    end else if (i_valid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_LAST) begin
                            r_state <= CLOSE;
                        end
                    end
                end
                CLOSE: begin
                    r_busy <= 1'b0;
                    if (r_bank != BANK_LAST) begin
                        r_bank  <= r_bank + 1'b1;
                        r_state <= IDLE;
                    end else if (WRAP_EN != 0) begin
                        r_bank  <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_full  <= 1'b1;
                        r_state <= FULL;
                    end
                end
                FULL: begin
                    r_state <= FULL;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    bank_len_table #(
        .BANK_NUM (BANK_NUM),
        .LEN_W    (DEPTH_W + 1)
    ) u_len_table (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_wr_en  (w_len_we),
        .i_wr_clr (w_len_clr),
        .i_wr_idx (r_bank),
        .i_wr_len (r_cnt),
        .i_rd_idx (i_len_bank),
        .o_rd_len (o_len)
    );

endmodule

// File: tb/tb_coord_bank_writer.sv
// Directed bench for coord_bank_writer: default instance plus two small
// instances (no-wrap and wrap) driven from the same stimulus.
module tb_coord_bank_writer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, valid, deny;
    logic [4:0] x, y;

    logic        d_we, d_busy, d_full;
    logic [4:0]  d_x, d_y, d_bank, d_lb;
    logic [14:0] d_addr;
    logic [10:0] d_len;

    logic        s_we, s_busy, s_full;
    logic [4:0]  s_x, s_y;
    logic [2:0]  s_addr, s_len;
    logic [0:0]  s_bank, s_lb;

    logic        w_we, w_busy, w_full;
    logic [4:0]  w_x, w_y;
    logic [2:0]  w_addr, w_len;
    logic [0:0]  w_bank, w_lb;

    int n_checks = 0;
    int n_fail   = 0;

    coord_bank_writer u_dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid),
        .i_x(x), .i_y(y), .i_deny(deny),
        .o_we(d_we), .o_x(d_x), .o_y(d_y), .o_addr(d_addr), .o_bank(d_bank),
        .o_busy(d_busy), .o_full(d_full), .i_len_bank(d_lb), .o_len(d_len)
    );

    coord_bank_writer #(.COORD_W(5), .BANK_NUM(2), .DEPTH_W(2), .WRAP_EN(0)) u_small (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid),
        .i_x(x), .i_y(y), .i_deny(deny),
        .o_we(s_we), .o_x(s_x), .o_y(s_y), .o_addr(s_addr), .o_bank(s_bank),
        .o_busy(s_busy), .o_full(s_full), .i_len_bank(s_lb), .o_len(s_len)
    );

    coord_bank_writer #(.COORD_W(5), .BANK_NUM(2), .DEPTH_W(2), .WRAP_EN(1)) u_wrap (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid),
        .i_x(x), .i_y(y), .i_deny(deny),
        .o_we(w_we), .o_x(w_x), .o_y(w_y), .o_addr(w_addr), .o_bank(w_bank),
        .o_busy(w_busy), .o_full(w_full), .i_len_bank(w_lb), .o_len(w_len)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic vl, input logic dn,
                         input logic [4:0] xv, input logic [4:0] yv);
        start = st;
        valid = vl;
        deny  = dn;
        x     = xv;
        y     = yv;
        #1;
    endtask

    task automatic reset_all();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b0;
        d_lb = '0; s_lb = '0; w_lb = '0;

        // 1: three writes then deny
        reset_all();
        check("rst_we",   d_we,   0);
        check("rst_addr", d_addr, 0);
        check("rst_bank", d_bank, 0);
        check("rst_busy", d_busy, 0);
        check("rst_full", d_full, 0);
        check("rst_len0", d_len,  0);
        drive(1, 0, 0, 0, 0); step();
        drive(0, 1, 0, 1, 4);
        check("t1_busy",  d_busy, 1);
        check("t1_we0",   d_we,   1);
        check("t1_addr0", d_addr, 0);
        check("t1_x0",    d_x,    1);
        check("t1_y0",    d_y,    4);
        step();
        drive(0, 1, 0, 2, 5);
        check("t1_we1",   d_we,   1);
        check("t1_addr1", d_addr, 1);
        step();
        drive(0, 1, 0, 3, 6);
        check("t1_addr2", d_addr, 2);
        check("t1_y2",    d_y,    6);
        step();
        drive(0, 0, 1, 0, 0);
        check("t1_deny_we", d_we, 0);
        step();
        drive(0, 0, 0, 0, 0);
        check("t1_close_busy", d_busy, 1);
        check("t1_close_we",   d_we,   0);
        step();
        drive(0, 0, 0, 0, 0);
        check("t1_idle_busy", d_busy, 0);
        check("t1_bank",      d_bank, 1);
        check("t1_len0",      d_len,  3);

        // 2: deny beats a same-cycle valid
        drive(1, 0, 0, 0, 0); step();
        drive(0, 1, 0, 7, 8);
        check("t2_addr0", d_addr, 1024);
        step();
        drive(0, 1, 0, 9, 10);
        check("t2_addr1", d_addr, 1025);
        step();
        drive(0, 1, 1, 11, 12);
        check("t2_we",  d_we, 0);
        check("t2_x",   d_x,  0);
        step();
        drive(0, 0, 0, 0, 0); step();
        d_lb = 5'd1;
        drive(0, 0, 0, 0, 0);
        check("t2_len1", d_len,  2);
        check("t2_bank", d_bank, 2);

        // 3: auto-close on a 4-entry bank
        reset_all();
        drive(1, 0, 0, 0, 0); step();
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 0, 5'(i + 1), 5'(i + 10));
            check($sformatf("t3_we%0d", i), s_we, (i < 4) ? 1 : 0);
            if (i < 4) check($sformatf("t3_addr%0d", i), s_addr, i);
            step();
        end
        s_lb = 1'b0; w_lb = 1'b0;
        drive(0, 0, 0, 0, 0);
        check("t3_len0",   s_len,  4);
        check("t3_bank",   s_bank, 1);
        check("t3_w_len0", w_len,  4);

        // 4: close last bank; no-wrap goes FULL, wrap returns to bank 0
        drive(1, 0, 0, 0, 0); step();
        drive(0, 0, 1, 0, 0); step();
        drive(0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0);
        check("t4_full",   s_full, 1);
        check("t4_busy",   s_busy, 0);
        check("t4_bank",   s_bank, 1);
        check("t4_w_bank", w_bank, 0);
        check("t4_w_full", w_full, 0);
        check("t4_w_len0", w_len,  4);
        s_lb = 1'b1;
        drive(0, 0, 0, 0, 0);
        check("t4_len1_zero", s_len, 0);
        drive(1, 1, 0, 3, 3); step();
        drive(0, 1, 0, 3, 3);
        check("t4_full_busy", s_busy, 0);
        check("t4_full_we",   s_we,   0);
        check("t4_full_hold", s_full, 1);
        check("t4_w_busy",    w_busy, 1);
        check("t4_w_len0_clr", w_len, 0);
        step();
        s_lb = 1'b0;
        drive(0, 0, 0, 0, 0);
        check("t4_full_len0", s_len, 4);

        // 5: reset in the middle of a session
        reset_all();
        d_lb = 5'd0;
        drive(1, 0, 0, 0, 0); step();
        drive(0, 1, 0, 1, 1); step();
        drive(0, 1, 0, 2, 2); step();
        drive(0, 0, 1, 0, 0); step();
        drive(0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0);
        check("t5_pre_len0", d_len,  2);
        check("t5_pre_bank", d_bank, 1);
        drive(1, 0, 0, 0, 0); step();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 5'(i), 5'(i)); step();
        end
        drive(0, 1, 0, 7, 7);
        check("t5_pre_addr", d_addr, 1024 + 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(0, 1, 0, 7, 7);
        check("t5_we",    d_we,   0);
        check("t5_x",     d_x,    0);
        check("t5_addr",  d_addr, 0);
        check("t5_bank",  d_bank, 0);
        check("t5_busy",  d_busy, 0);
        check("t5_full",  d_full, 0);
        check("t5_len0",  d_len,  0);
        d_lb = 5'd26;
        drive(0, 0, 0, 0, 0);
        check("t5_len_oor26", d_len, 0);
        d_lb = 5'd31;
        drive(0, 0, 0, 0, 0);
        check("t5_len_oor31", d_len, 0);

        // 6: zero-length session; valid during CLOSE is dropped
        d_lb = 5'd0;
        drive(1, 0, 0, 0, 0); step();
        drive(0, 0, 1, 0, 0);
        check("t6_work_busy", d_busy, 1);
        step();
        drive(0, 1, 0, 5, 5);
        check("t6_close_we", d_we, 0);
        step();
        drive(0, 0, 0, 0, 0);
        check("t6_bank", d_bank, 1);
        check("t6_len0", d_len,  0);
        check("t6_busy", d_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
